// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, action table and frame FSM states for the PS/2 decoder
`timescale 1ns/1ps
package ps2_pkg;

  localparam logic [7:0] EXT_CODE = 8'hE0;
  localparam logic [7:0] BRK_CODE = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } action_key_t;

  // Row k drives acoes[k]; only the first N_ACTIONS rows are used.
  localparam action_key_t ACTION_TABLE [8] = '{
    '{ext: 1'b1, code: 8'h75},
    '{ext: 1'b1, code: 8'h6B},
    '{ext: 1'b1, code: 8'h72},
    '{ext: 1'b1, code: 8'h74},
    '{ext: 1'b0, code: 8'h5A},
    '{ext: 1'b0, code: 8'h29},
    '{ext: 1'b0, code: 8'h76},
    '{ext: 1'b0, code: 8'h1D}
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  function automatic logic key_match(input action_key_t entry, input logic ext,
                                     input logic [7:0] code);
    return (entry.ext == ext) && (entry.code == code);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pin conditioning and 11-bit frame receiver with timeout
`timescale 1ns/1ps
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_good,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FL_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_clk;
  logic [FW-1:0] flt_cnt;
  logic          fall_stb;

  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;

  wire data_s = data_sync[1];

  // Pins idle high, so the synchronisers and the filter reset to 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_clk  <= 1'b1;
      flt_cnt   <= '0;
      fall_stb  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall_stb  <= 1'b0;
      if (clk_sync[1] != filt_clk) begin
        if (flt_cnt == FL_MAX) begin
          filt_clk <= clk_sync[1];
          flt_cnt  <= '0;
          fall_stb <= filt_clk;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      rx_byte    <= '0;
      byte_good  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_good  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (fall_stb || state == ST_IDLE) to_cnt <= '0;
      else                              to_cnt <= to_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (fall_stb && !data_s) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (fall_stb) begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (fall_stb) begin
            par_bit <= data_s;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (fall_stb) begin
            state <= ST_IDLE;
            if (^{shift, par_bit} == 1'b0) parity_err <= 1'b1;
            else if (!data_s)              frame_err  <= 1'b1;
            else begin
              byte_good <= 1'b1;
              rx_byte   <= shift;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A stalled frame is abandoned; the partial byte is simply never reported.
      if (state != ST_IDLE && !fall_stb && to_cnt == TO_MAX) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        to_cnt    <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_action_decoder.sv
// rtl/ps2_action_decoder.sv - PS/2 receiver with scan-code FIFO and held-key action decoder
`timescale 1ns/1ps
module ps2_action_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int N_ACTIONS   = 5,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             ps2_clk,
  input  logic                             ps2_data,
  input  logic                             rd_en,
  output logic [7:0]                       scan_code,
  output logic                             scan_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic [N_ACTIONS-1:0]             acoes,
  output logic                             parity_err,
  output logic                             frame_err,
  output logic                             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    rx_byte;
  logic          byte_good;
  logic          rx_parity_err;
  logic          rx_frame_err;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_good (byte_good),
    .parity_err(rx_parity_err),
    .frame_err (rx_frame_err)
  );

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ext;
  logic          brk;

  wire full    = (count == CW'(FIFO_DEPTH));
  wire do_pop  = rd_en && (count != '0);
  wire do_push = byte_good && (!full || do_pop);

  assign scan_valid = (count != '0);
  assign scan_code  = scan_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_count = count;
  assign parity_err = rx_parity_err;
  assign frame_err  = rx_frame_err;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= rx_byte;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= byte_good && full && !do_pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // The decoder tracks every good byte even when the FIFO has to drop it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ext   <= 1'b0;
      brk   <= 1'b0;
      acoes <= '0;
    end else if (byte_good) begin
      if (rx_byte == EXT_CODE) begin
        ext <= 1'b1;
      end else if (rx_byte == BRK_CODE) begin
        brk <= 1'b1;
      end else begin
        for (int k = 0; k < N_ACTIONS; k++) begin
          if (key_match(ACTION_TABLE[k], ext, rx_byte)) acoes[k] <= !brk;
        end
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end else if (rx_parity_err || rx_frame_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_action_decoder.sv
// tb/tb_ps2_action_decoder.sv - self-checking bench for ps2_action_decoder
`timescale 1ns/1ps
module tb_ps2_action_decoder;

  localparam int DEPTH = 8;
  localparam int NA    = 5;
  localparam int FL    = 4;
  localparam int TO    = 2000;
  localparam int HALF  = 12;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          rd_en = 1'b0;
  logic [7:0]    scan_code;
  logic          scan_valid;
  logic [CW-1:0] fifo_count;
  logic [NA-1:0] acoes;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;

  ps2_action_decoder #(
    .FIFO_DEPTH (DEPTH),
    .N_ACTIONS  (NA),
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .fifo_count(fifo_count),
    .acoes     (acoes),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int perr_cyc = 0, ferr_cyc = 0, ovf_cyc = 0;
  int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;

  logic [7:0]    m_q [$];
  logic [NA-1:0] m_acoes = '0;
  bit            m_ext = 1'b0;
  bit            m_brk = 1'b0;

  logic [7:0] t_code [8] = '{8'h75, 8'h6B, 8'h72, 8'h74, 8'h5A, 8'h29, 8'h76, 8'h1D};
  bit         t_ext  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  typedef struct {
    logic [7:0]    code;
    logic [NA-1:0] exp_acoes;
    int            exp_count;
  } vec_t;
  vec_t vecs [5];

  always @(negedge clock) begin
    if (parity_err) perr_cyc++;
    if (frame_err)  ferr_cyc++;
    if (overflow)   ovf_cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_apply(input logic [7:0] b, input bit par_ok, input bit stop_ok);
    if (!par_ok) begin
      exp_perr++;
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (!stop_ok) begin
      exp_ferr++;
      m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else exp_ovf++;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        for (int k = 0; k < NA; k++)
          if (t_ext[k] == m_ext && t_code[k] == b) m_acoes[k] = !m_brk;
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_acoes = '0;
    m_ext = 1'b0; m_brk = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " scan_valid"}, scan_valid, m_q.size() != 0);
    chk({tag, " scan_code"},  scan_code,  (m_q.size() != 0) ? m_q[0] : 8'h00);
    chk({tag, " fifo_count"}, fifo_count, m_q.size());
    chk({tag, " acoes"},      acoes,      m_acoes);
    chk({tag, " parity_err pulses"}, perr_cyc, exp_perr);
    chk({tag, " frame_err pulses"},  ferr_cyc, exp_ferr);
    chk({tag, " overflow pulses"},   ovf_cyc,  exp_ovf);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock) ps2_data = f[i];
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clock);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_frame(b, bad_par, bad_stop, 11);
    model_apply(b, !bad_par, !bad_stop);
  endtask

  task automatic pop();
    @(negedge clock) rd_en = 1'b1;
    @(negedge clock) rd_en = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
  endtask

  task automatic drain();
    while (m_q.size() != 0) pop();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " scan_code"},  scan_code,  8'h00);
    chk({tag, " scan_valid"}, scan_valid, 1'b0);
    chk({tag, " fifo_count"}, fifo_count, 0);
    chk({tag, " acoes"},      acoes,      0);
    chk({tag, " parity_err"}, parity_err, 1'b0);
    chk({tag, " frame_err"},  frame_err,  1'b0);
    chk({tag, " overflow"},   overflow,   1'b0);
  endtask

  initial begin
    int  p0, f0, o0;
    bit  hit;
    logic [7:0] b;
    int  r;

    vecs[0] = '{code: 8'hE0, exp_acoes: 5'b00000, exp_count: 1};
    vecs[1] = '{code: 8'h75, exp_acoes: 5'b00001, exp_count: 2};
    vecs[2] = '{code: 8'hE0, exp_acoes: 5'b00001, exp_count: 3};
    vecs[3] = '{code: 8'hF0, exp_acoes: 5'b00001, exp_count: 4};
    vecs[4] = '{code: 8'h75, exp_acoes: 5'b00000, exp_count: 5};

    repeat (4) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // make/break through the table
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].code, 1'b0, 1'b0);
      chk($sformatf("vec%0d acoes", i), acoes, vecs[i].exp_acoes);
      chk($sformatf("vec%0d fifo_count", i), fifo_count, vecs[i].exp_count);
    end
    chk("vec head scan_code", scan_code, 8'hE0);
    check_model("vec");
    drain();

    // single make code, then pop
    chk("5a pre scan_valid", scan_valid, 1'b0);
    send(8'h5A, 1'b0, 1'b0);
    chk("5a acoes[4]", acoes[4], 1'b1);
    chk("5a scan_valid", scan_valid, 1'b1);
    pop();
    chk("5a pop scan_valid", scan_valid, 1'b0);
    chk("5a pop fifo_count", fifo_count, 0);

    // parity error, then error clearing the extended prefix
    p0 = perr_cyc;
    send(8'h5A, 1'b1, 1'b0);
    chk("perr pulse cycles", perr_cyc - p0, 1);
    check_model("perr");
    send(8'hE0, 1'b0, 1'b0);
    send(8'h75, 1'b1, 1'b0);
    send(8'h75, 1'b0, 1'b0);
    chk("ext cleared acoes[0]", acoes[0], 1'b0);
    check_model("ext_clear");
    drain();

    // overflow
    o0 = ovf_cyc;
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b0);
    chk("ovf fifo_count", fifo_count, DEPTH);
    chk("ovf pulse cycles", ovf_cyc - o0, 1);
    chk("ovf scan_code", scan_code, 8'h01);

    // push and pop in the same cycle while full
    hit = 1'b0;
    fork
      send_frame(8'h0A, 1'b0, 1'b0, 11);
      begin
        for (int i = 0; i < 600; i++) begin
          @(negedge clock);
          if (dut.u_rx.byte_good) begin
            hit = 1'b1;
            break;
          end
        end
        if (hit) begin
          rd_en = 1'b1;
          @(negedge clock) rd_en = 1'b0;
        end
      end
    join
    chk("full push+pop byte seen", hit, 1'b1);
    void'(m_q.pop_front());
    model_apply(8'h0A, 1'b1, 1'b1);
    chk("full push+pop fifo_count", fifo_count, DEPTH);
    chk("full push+pop scan_code", scan_code, 8'h02);
    check_model("full_pushpop");
    drain();

    // timeout mid-frame
    f0 = ferr_cyc;
    send_frame(8'h00, 1'b0, 1'b0, 5);
    repeat (TO + 50) @(negedge clock);
    exp_ferr++;
    m_ext = 1'b0; m_brk = 1'b0;
    chk("timeout pulse cycles", ferr_cyc - f0, 1);
    send(8'h29, 1'b0, 1'b0);
    chk("after timeout scan_code", scan_code, 8'h29);
    check_model("timeout");
    drain();

    // short glitch while idle must not start a frame
    @(negedge clock);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (FL - 1) @(negedge clock);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (30) @(negedge clock);
    send(8'h5A, 1'b0, 1'b0);
    check_model("glitch");

    // asynchronous reset mid-frame
    send_frame(8'h33, 1'b0, 1'b0, 4);
    @(negedge clock) reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    send(8'h5A, 1'b0, 1'b0);
    check_model("post_reset");

    // randomized frames against the model
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 9:    b = 8'hE0;
        1:       b = 8'hF0;
        2, 3, 4: b = t_code[$urandom_range(0, 3)];
        5:       b = 8'h5A;
        6:       b = 8'h29;
        default: b = 8'($urandom_range(0, 255));
      endcase
      r = $urandom_range(0, 19);
      send(b, r == 0, r == 1);
      repeat ($urandom_range(0, 2)) pop();
      check_model($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
